mem_burst_ctrl: RTL and testbench

MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

---
 rtl/mem_burst_pkg.sv | 16 +
 rtl/mem_burst_rd_buf.sv | 33 +++
 rtl/mem_burst_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_burst_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// Shared types and default widths for the memory burst controller.
package mem_burst_pkg;

  localparam int unsigned DEF_ADR_W  = 16;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } burstState_t;

endpackage

// File: rtl/mem_burst_rd_buf.sv
// One-entry read output register with valid/ready handshake.
module mem_burst_rd_buf
  import mem_burst_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadEn,
  input  logic [DATA_W-1:0] loadData,
  output logic              canLoad,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata
);

  // A new beat may enter when the slot is empty or is being consumed now.
  assign canLoad = !rdata_valid || rdata_ready;

  // Hold the beat until consumed; a load always wins over a plain consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else if (loadEn) begin
      rdata_valid <= 1'b1;
      rdata       <= loadData;
    end else if (rdata_ready) begin
      rdata_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller between a request/stream interface and a simple RAM.
// Optional build macro MEM_BURST_ERR_EN: reject bursts that would run past
// the top of the address space (err pulse) instead of wrapping.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int unsigned ADR_W  = DEF_ADR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADR_W-1:0]  req_adr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic [ADR_W-1:0]  adr,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEn,
  input  logic [DATA_W-1:0] readData,
  output logic              done,
  output logic              err
);

  burstState_t      state, stateNext;
  logic [ADR_W-1:0] curAdr, curAdrNext;
  logic [LEN_W-1:0] beatsLeft, beatsLeftNext;
  logic             readGo, readGoNext;
  logic             bufLoad, bufCanLoad;
  logic             reqOverflow;

`ifdef MEM_BURST_ERR_EN
  localparam int unsigned SUM_W = ADR_W + 1;
  logic [SUM_W-1:0] reqEnd;

  // Last beat address with a carry bit; carry set means the burst overruns.
  assign reqEnd      = SUM_W'(req_adr) + SUM_W'(req_len);
  assign reqOverflow = reqEnd[ADR_W];

  // Single-cycle err pulse for each rejected handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= (state == IDLE) && req_valid && reqOverflow;
  end
`else
  assign reqOverflow = 1'b0;
  assign err         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Burst bookkeeping registers and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curAdr    <= '0;
      beatsLeft <= '0;
      readGo    <= 1'b0;
      done      <= 1'b0;
    end else begin
      curAdr    <= curAdrNext;
      beatsLeft <= beatsLeftNext;
      readGo    <= readGoNext;
      done      <= (stateNext == DONE);
    end
  end

  // Next-state, bookkeeping updates and RAM-side strobes.
  always_comb begin
    stateNext     = state;
    curAdrNext    = curAdr;
    beatsLeftNext = beatsLeft;
    readGoNext    = 1'b0;
    req_ready     = 1'b0;
    wdata_ready   = 1'b0;
    writeEn       = 1'b0;
    adr           = '0;
    writeData     = '0;
    bufLoad       = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !reqOverflow) begin
          curAdrNext    = req_adr;
          beatsLeftNext = req_len;
          stateNext     = req_write ? WRITE : READ;
        end
      end

      WRITE: begin
        adr         = curAdr;
        writeData   = wdata;
        wdata_ready = 1'b1;
        writeEn     = wdata_valid;
        if (wdata_valid) begin
          curAdrNext = curAdr + ADR_W'(1);
          if (beatsLeft == '0) stateNext = DONE;
          else                 beatsLeftNext = beatsLeft - LEN_W'(1);
        end
      end

      // First READ cycle only settles the RAM address; sampling starts after.
      READ: begin
        adr        = curAdr;
        readGoNext = 1'b1;
        if (readGo && bufCanLoad) begin
          bufLoad    = 1'b1;
          curAdrNext = curAdr + ADR_W'(1);
          if (beatsLeft == '0) stateNext = DRAIN;
          else                 beatsLeftNext = beatsLeft - LEN_W'(1);
        end
      end

      DRAIN: begin
        if (bufCanLoad) stateNext = DONE;
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  mem_burst_rd_buf #(
    .DATA_W(DATA_W)
  ) u_rd_buf (
    .clk        (clk),
    .rst        (rst),
    .loadEn     (bufLoad),
    .loadData   (readData),
    .canLoad    (bufCanLoad),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .rdata      (rdata)
  );

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl with a behavioural RAM and burst model.
module tb_mem_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_adr;
  logic [7:0]  req_len;
  logic        wdata_valid, wdata_ready;
  logic [63:0] wdata;
  logic        rdata_valid, rdata_ready;
  logic [63:0] rdata;
  logic [15:0] adr;
  logic [63:0] writeData;
  logic        writeEn;
  logic [63:0] readData;
  logic        done, err;

  int nTests = 0;
  int nFail  = 0;

  bit [63:0] ram    [0:65535];
  bit [63:0] refMem [0:65535];

  always #5 clk = ~clk;

  mem_burst_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_adr    (req_adr),
    .req_len    (req_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .rdata      (rdata),
    .adr        (adr),
    .writeData  (writeData),
    .writeEn    (writeEn),
    .readData   (readData),
    .done       (done),
    .err        (err)
  );

  // RAM: combinational read, posedge write.
  assign readData = ram[adr];
  always @(posedge clk) if (writeEn) ram[adr] <= writeData;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, "_req_ready"},   64'(req_ready),   64'(1));
    chk({tag, "_wdata_ready"}, 64'(wdata_ready), 64'(0));
    chk({tag, "_rdata_valid"}, 64'(rdata_valid), 64'(0));
    chk({tag, "_rdata"},       rdata,            64'(0));
    chk({tag, "_done"},        64'(done),        64'(0));
    chk({tag, "_err"},         64'(err),         64'(0));
    chk({tag, "_adr"},         64'(adr),         64'(0));
    chk({tag, "_writeData"},   writeData,        64'(0));
    chk({tag, "_writeEn"},     64'(writeEn),     64'(0));
  endtask

  // Write burst; mode 0 = no stalls, 1 = random stalls, 2 = valid toggles 1,0,1,...
  task automatic doWrite(input logic [15:0] a, input logic [7:0] len, input int mode, input bit seqData);
    int cyc, beat, doneCyc;
    bit fin, v;
    logic [15:0] ea;
    logic [63:0] d;
    req_valid = 1'b1; req_write = 1'b1; req_adr = a; req_len = len; wdata_valid = 1'b0;
    @(negedge clk);
    chk("w_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    cyc = 0; beat = 0; doneCyc = -1; fin = 1'b0;
    while (!fin && cyc < 400) begin
      #1;
      req_valid = 1'b0;
      ea = 16'(int'(a) + beat);
      d  = seqData ? 64'(10 + beat) : {$urandom, $urandom};
      case (mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = (cyc % 2 == 0);
      endcase
      v = v && (beat <= int'(len));
      wdata_valid = v; wdata = d;
      @(negedge clk);
      chk("w_wdata_ready", 64'(wdata_ready), 64'(beat <= int'(len)));
      chk("w_writeEn", 64'(writeEn), 64'(v));
      if (v) begin
        chk("w_adr", 64'(adr), 64'(ea));
        chk("w_writeData", writeData, d);
      end
      chk("w_done", 64'(done), 64'(cyc == doneCyc));
      chk("w_err", 64'(err), 64'(0));
      if (cyc == doneCyc) fin = 1'b1;
      @(posedge clk);
      if (v) begin
        refMem[ea] = d;
        beat++;
        if (beat == int'(len) + 1) doneCyc = cyc + 1;
      end
      cyc++;
    end
    if (!fin) chk("w_timeout", 64'(0), 64'(1));
    #1; wdata_valid = 1'b0;
    @(negedge clk);
    chk("w_back_idle", 64'(req_ready), 64'(1));
    chk("w_done_once", 64'(done), 64'(0));
    @(posedge clk); #1;
  endtask

  // Read burst; mode 0 = always ready, 1 = random ready, 2 = ready low in cycles 2..4.
  task automatic doRead(input logic [15:0] a, input logic [7:0] len, input int mode);
    int cyc, beat, doneCyc;
    bit fin, rdy, consume;
    req_valid = 1'b1; req_write = 1'b0; req_adr = a; req_len = len; rdata_ready = 1'b0;
    @(negedge clk);
    chk("r_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    cyc = 0; beat = 0; doneCyc = -1; fin = 1'b0;
    while (!fin && cyc < 400) begin
      #1;
      req_valid = 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(cyc >= 2 && cyc <= 4);
      endcase
      rdata_ready = rdy;
      @(negedge clk);
      if (cyc < 2)  chk("r_early_valid", 64'(rdata_valid), 64'(0));
      if (cyc == 2) chk("r_first_latency", 64'(rdata_valid), 64'(1));
      if (mode == 0) chk("r_stream", 64'(rdata_valid), 64'(cyc >= 2 && cyc <= 2 + int'(len)));
      if (rdata_valid === 1'b1) begin
        chk("r_extra_beat", 64'(beat <= int'(len)), 64'(1));
        chk("r_data", rdata, refMem[16'(int'(a) + beat)]);
      end
      chk("r_writeEn", 64'(writeEn), 64'(0));
      chk("r_done", 64'(done), 64'(cyc == doneCyc));
      chk("r_err", 64'(err), 64'(0));
      if (cyc == doneCyc) fin = 1'b1;
      consume = (rdata_valid === 1'b1) && rdy;
      @(posedge clk);
      if (consume) begin
        beat++;
        if (beat == int'(len) + 1) doneCyc = cyc + 1;
      end
      cyc++;
    end
    if (!fin) chk("r_timeout", 64'(0), 64'(1));
    #1; rdata_ready = 1'b0;
    @(negedge clk);
    chk("r_back_idle", 64'(req_ready), 64'(1));
    chk("r_valid_clear", 64'(rdata_valid), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rl;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_adr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chkIdle("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;

    // Sequential data 0xA..0xD at 0x10, then read back streaming and with backpressure.
    doWrite(16'h0010, 8'd3, 0, 1'b1);
    doRead(16'h0010, 8'd3, 0);
    doRead(16'h0010, 8'd1, 2);

`ifdef MEM_BURST_ERR_EN
    req_valid = 1'b1; req_write = 1'b1; req_adr = 16'hFFFF; req_len = 8'd1; wdata_valid = 1'b1;
    @(negedge clk);
    chk("e_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("e_err_pulse", 64'(err), 64'(1));
    chk("e_writeEn", 64'(writeEn), 64'(0));
    chk("e_stay_idle", 64'(req_ready), 64'(1));
    @(posedge clk); #1 wdata_valid = 1'b0;
    @(negedge clk);
    chk("e_err_once", 64'(err), 64'(0));
    chk("e_writeEn2", 64'(writeEn), 64'(0));
    @(posedge clk); #1;
`else
    doWrite(16'hFFFF, 8'd1, 0, 1'b0);
    doRead(16'hFFFF, 8'd1, 0);
`endif

    // Toggling write valid, then random-ready read of it.
    doWrite(16'h0100, 8'd2, 2, 1'b0);
    doRead(16'h0100, 8'd2, 1);

    // Single-beat bursts.
    doWrite(16'h0200, 8'd0, 0, 1'b0);
    doRead(16'h0200, 8'd0, 0);

    // Reset during the third beat of an 8-beat write.
    req_valid = 1'b1; req_write = 1'b1; req_adr = 16'h0300; req_len = 8'd7;
    @(negedge clk);
    chk("m_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1 req_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wdata_valid = 1'b1; wdata = {$urandom, $urandom};
      @(negedge clk);
      chk("m_writeEn", 64'(writeEn), 64'(1));
      @(posedge clk);
      refMem[16'(16'h0300 + b)] = wdata;
      #1;
    end
    wdata = {$urandom, $urandom};
    @(negedge clk);
    chk("m_third_beat", 64'(writeEn), 64'(1));
    #2 rst = 1'b1;
    #1 chkIdle("mid_reset");
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("m_no_write", 64'(writeEn), 64'(0));
      chk("m_no_done", 64'(done), 64'(0));
      chk("m_ready", 64'(req_ready), 64'(1));
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    doRead(16'h0300, 8'd7, 0);

    // Random bursts: write then read back each region.
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom_range(0, 16'hFF00));
      rl = 8'($urandom_range(0, 7));
      doWrite(ra, rl, int'($urandom_range(0, 2)), 1'b0);
      doRead(ra, rl, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
